// File: rtl/mips_pkg.sv
// Shared constants for the PIPELINE_MIPS32 memory arbiter: response-owner
// encoding and requester indices used by the grant vectors.
package mips_pkg;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_DBG  = 2'd1;
    localparam logic [1:0] RSP_DMEM = 2'd2;
    localparam logic [1:0] RSP_IMEM = 2'd3;

    localparam int REQ_DBG  = 0;
    localparam int REQ_DMEM = 1;
    localparam int REQ_IMEM = 2;
    localparam int NUM_REQ  = 3;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of requester, memory-side and debug-visibility signals around the
// unified-memory arbiter. The arbiter uses the slave modport.
interface mips_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Handshake: a requester holds req/we/addr/wdata stable until gnt; the
    // access happens in the cycle where req & gnt is high. Read data returns
    // exactly one cycle later on rdata_o, qualified by that requester's rvalid.
    logic              halt_i;
    logic              dbg_req,  dmem_req,  imem_req;
    logic              dbg_we,   dmem_we;
    logic [ADDR_W-1:0] dbg_addr, dmem_addr, imem_addr;
    logic [DATA_W-1:0] dbg_wdata, dmem_wdata;
    logic              dbg_gnt,  dmem_gnt,  imem_gnt;
    logic              dbg_rvalid, dmem_rvalid, imem_rvalid;
    logic [DATA_W-1:0] rdata_o;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [3:0]        starve_cnt;
    logic [1:0]        rsp_owner;

    modport slave (
        input  halt_i,
        input  dbg_req, dmem_req, imem_req,
        input  dbg_we, dmem_we,
        input  dbg_addr, dmem_addr, imem_addr,
        input  dbg_wdata, dmem_wdata,
        output dbg_gnt, dmem_gnt, imem_gnt,
        output dbg_rvalid, dmem_rvalid, imem_rvalid,
        output rdata_o,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output starve_cnt, rsp_owner
    );

    modport master (
        output halt_i,
        output dbg_req, dmem_req, imem_req,
        output dbg_we, dmem_we,
        output dbg_addr, dmem_addr, imem_addr,
        output dbg_wdata, dmem_wdata,
        input  dbg_gnt, dmem_gnt, imem_gnt,
        input  dbg_rvalid, dmem_rvalid, imem_rvalid,
        input  rdata_o,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  starve_cnt, rsp_owner
    );

endinterface

// File: rtl/mips_prio_grant.sv
// Three-way fixed-priority picker (dbg > dmem > imem); promote_i lifts imem
// above dmem but never above dbg.
module mips_prio_grant
    import mips_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               promote_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req_i[REQ_DBG]) begin
            gnt_o[REQ_DBG] = 1'b1;
        end else if (promote_i && req_i[REQ_IMEM]) begin
            gnt_o[REQ_IMEM] = 1'b1;
        end else if (req_i[REQ_DMEM]) begin
            gnt_o[REQ_DMEM] = 1'b1;
        end else if (req_i[REQ_IMEM]) begin
            gnt_o[REQ_IMEM] = 1'b1;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port arbiter for the unified MIPS32 word memory: one access per cycle,
// one-cycle read return routed to the issuer, and fetch anti-starvation.
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input logic               clk,
    input logic               rst,
    mips_mem_arbiter_if.slave bus
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    logic               promote;
    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic [1:0]         rsp_owner_q, rsp_owner_d;
    logic               we_mux;
    logic [ADDR_W-1:0]  addr_mux;
    logic [DATA_W-1:0]  wdata_mux;
    logic               rsp_live;

    // Reset masks requests so nothing is granted or strobed in the reset cycle.
    always_comb begin
        req_vec = '0;
        if (!rst) begin
            req_vec[REQ_DBG]  = bus.dbg_req;
            req_vec[REQ_DMEM] = bus.dmem_req;
            req_vec[REQ_IMEM] = bus.imem_req & ~bus.halt_i;
        end
    end

    assign promote = (starve_cnt_q == LIM);

    mips_prio_grant u_prio (
        .req_i     (req_vec),
        .promote_i (promote),
        .gnt_o     (gnt_vec)
    );

    assign bus.dbg_gnt  = gnt_vec[REQ_DBG];
    assign bus.dmem_gnt = gnt_vec[REQ_DMEM];
    assign bus.imem_gnt = gnt_vec[REQ_IMEM];

    always_comb begin
        we_mux      = 1'b0;
        addr_mux    = '0;
        wdata_mux   = '0;
        rsp_owner_d = RSP_NONE;
        if (gnt_vec[REQ_DBG]) begin
            we_mux    = bus.dbg_we;
            addr_mux  = bus.dbg_addr;
            wdata_mux = bus.dbg_wdata;
            if (!bus.dbg_we) rsp_owner_d = RSP_DBG;
        end else if (gnt_vec[REQ_DMEM]) begin
            we_mux    = bus.dmem_we;
            addr_mux  = bus.dmem_addr;
            wdata_mux = bus.dmem_wdata;
            if (!bus.dmem_we) rsp_owner_d = RSP_DMEM;
        end else if (gnt_vec[REQ_IMEM]) begin
            addr_mux    = bus.imem_addr;
            rsp_owner_d = RSP_IMEM;
        end
    end

    assign bus.mem_en    = |gnt_vec;
    assign bus.mem_we    = we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    // Counts consecutive cycles where fetch wanted memory and lost; saturates.
    always_comb begin
        starve_cnt_d = '0;
        if (bus.imem_req && !gnt_vec[REQ_IMEM] && !bus.halt_i) begin
            starve_cnt_d = (starve_cnt_q >= LIM) ? LIM : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rsp_owner_q  <= RSP_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_owner_q  <= rsp_owner_d;
        end
    end

    // A read in flight when reset arrives is silently dropped.
    assign rsp_live        = !rst && (rsp_owner_q != RSP_NONE);
    assign bus.dbg_rvalid  = !rst && (rsp_owner_q == RSP_DBG);
    assign bus.dmem_rvalid = !rst && (rsp_owner_q == RSP_DMEM);
    assign bus.imem_rvalid = !rst && (rsp_owner_q == RSP_IMEM);
    assign bus.rdata_o     = rsp_live ? bus.mem_rdata : '0;

    assign bus.starve_cnt = starve_cnt_q;
    assign bus.rsp_owner  = rsp_owner_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: requester agents, a memory model, a reference
// arbitration model feeding an expected-read queue, and a read-return monitor.
module tb_mips_mem_arbiter;
    import mips_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int STARVE_LIM = 4;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int EXP_W      = 32 + 2 + DATA_W;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mips_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mips_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    logic [DATA_W-1:0] mem    [DEPTH];
    logic [DATA_W-1:0] shadow [DEPTH];
    logic [EXP_W-1:0]  exp_q[$];
    txn_t              agent_q[3][$];
    logic [2:0]        gnt_seen = '0;
    int                model_starve = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory array: registered read, write at the strobe edge.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    always @(negedge clk) gnt_seen = {bus.imem_gnt, bus.dmem_gnt, bus.dbg_gnt};

    // Requester agents: present the head of each queue, retire it once granted.
    initial begin
        bus.dbg_req  = 0; bus.dmem_req  = 0; bus.imem_req  = 0;
        bus.dbg_we   = 0; bus.dmem_we   = 0;
        bus.dbg_addr = 0; bus.dmem_addr = 0; bus.imem_addr = 0;
        bus.dbg_wdata = 0; bus.dmem_wdata = 0;
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < 3; p++)
                if (gnt_seen[p] && agent_q[p].size() > 0) void'(agent_q[p].pop_front());
            bus.dbg_req = 0; bus.dmem_req = 0; bus.imem_req = 0;
            if (agent_q[REQ_DBG].size() > 0) begin
                bus.dbg_req   = 1;
                bus.dbg_we    = agent_q[REQ_DBG][0].we;
                bus.dbg_addr  = agent_q[REQ_DBG][0].addr;
                bus.dbg_wdata = agent_q[REQ_DBG][0].wdata;
            end
            if (agent_q[REQ_DMEM].size() > 0) begin
                bus.dmem_req   = 1;
                bus.dmem_we    = agent_q[REQ_DMEM][0].we;
                bus.dmem_addr  = agent_q[REQ_DMEM][0].addr;
                bus.dmem_wdata = agent_q[REQ_DMEM][0].wdata;
            end
            if (agent_q[REQ_IMEM].size() > 0) begin
                bus.imem_req  = 1;
                bus.imem_addr = agent_q[REQ_IMEM][0].addr;
            end
        end
    end

    // Reference model: decides the winner from the arbitration rules, checks
    // the memory-side strobe and schedules the expected read return.
    task automatic model_step();
        int                win;
        bit                imem_ok;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [1:0]        owner;
        logic [2:0]        eg;
        imem_ok = bus.imem_req && !bus.halt_i;
        win = -1;
        if (!rst) begin
            if (bus.dbg_req)                                  win = REQ_DBG;
            else if (imem_ok && model_starve == STARVE_LIM)   win = REQ_IMEM;
            else if (bus.dmem_req)                            win = REQ_DMEM;
            else if (imem_ok)                                 win = REQ_IMEM;
        end
        eg = (win < 0) ? 3'b000 : 3'(1 << win);
        we = 0; addr = 0; wd = 0; owner = RSP_NONE;
        case (win)
            REQ_DBG:  begin we = bus.dbg_we;  addr = bus.dbg_addr;  wd = bus.dbg_wdata;  owner = RSP_DBG;  end
            REQ_DMEM: begin we = bus.dmem_we; addr = bus.dmem_addr; wd = bus.dmem_wdata; owner = RSP_DMEM; end
            REQ_IMEM: begin addr = bus.imem_addr; owner = RSP_IMEM; end
            default: ;
        endcase
        check("gnt", 64'({bus.imem_gnt, bus.dmem_gnt, bus.dbg_gnt}), 64'(eg));
        check("starve_cnt", 64'(bus.starve_cnt), 64'(model_starve));
        check("mem_en", 64'(bus.mem_en), 64'(win >= 0));
        check("mem_we", 64'(bus.mem_we), 64'(we));
        if (rst) begin
            check("mem_addr_rst", 64'(bus.mem_addr), 64'd0);
            check("mem_wdata_rst", 64'(bus.mem_wdata), 64'd0);
        end else if (win >= 0) begin
            check("mem_addr", 64'(bus.mem_addr), 64'(addr));
            if (we) begin
                check("mem_wdata", 64'(bus.mem_wdata), 64'(wd));
                shadow[addr] = wd;
            end else begin
                exp_q.push_back({32'(cyc + 1), owner, shadow[addr]});
            end
        end
        if (rst) model_starve = 0;
        else if (imem_ok && win != REQ_IMEM)
            model_starve = (model_starve + 1 > STARVE_LIM) ? STARVE_LIM : model_starve + 1;
        else model_starve = 0;
    endtask

    always @(negedge clk) if (cyc != 0) model_step();

    // Monitor: every cycle, the read return must match the queue head due now.
    always @(negedge clk) begin
        logic [2:0]       rv;
        logic [2:0]       erv;
        logic [EXP_W-1:0] e;
        if (cyc != 0) begin
            rv = {bus.imem_rvalid, bus.dmem_rvalid, bus.dbg_rvalid};
            if (rst) begin
                while (exp_q.size() > 0 && exp_q[0][EXP_W-1 -: 32] <= cyc) void'(exp_q.pop_front());
                check("rvalid_rst", 64'(rv), 64'd0);
                check("rdata_rst", 64'(bus.rdata_o), 64'd0);
            end else if (exp_q.size() > 0 && exp_q[0][EXP_W-1 -: 32] == cyc) begin
                e = exp_q.pop_front();
                case (e[DATA_W +: 2])
                    RSP_DBG:  erv = 3'b001;
                    RSP_DMEM: erv = 3'b010;
                    default:  erv = 3'b100;
                endcase
                check("rvalid", 64'(rv), 64'(erv));
                check("rdata", 64'(bus.rdata_o), 64'(e[DATA_W-1:0]));
            end else begin
                check("rvalid_idle", 64'(rv), 64'd0);
            end
        end
    end

    function automatic txn_t mk(input logic we, input int addr, input logic [DATA_W-1:0] wd);
        txn_t t;
        t.we = we; t.addr = ADDR_W'(addr); t.wdata = wd;
        return t;
    endfunction

    task automatic wait_drain();
        int n = 0;
        while ((agent_q[0].size() + agent_q[1].size() + agent_q[2].size() + exp_q.size()) != 0 && n < 2000) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL drain_timeout cyc=%0d actual=pending required=empty", cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int first, last, cnt;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom; shadow[i] = mem[i];
        end
        bus.halt_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Loader write then read-back.
        @(negedge clk);
        agent_q[REQ_DBG].push_back(mk(1, 0, 32'h28010005));
        agent_q[REQ_DBG].push_back(mk(0, 0, 0));
        wait_drain();
        check("loader_mem0", 64'(mem[0]), 64'h28010005);

        // Contention: dmem first, imem next cycle alongside dmem's return.
        agent_q[REQ_DMEM].push_back(mk(0, 5, 0));
        agent_q[REQ_IMEM].push_back(mk(0, 1, 0));
        @(negedge clk);
        check("cont_dmem_gnt", 64'({bus.imem_gnt, bus.dmem_gnt}), 64'b01);
        @(negedge clk);
        check("cont_imem_gnt", 64'({bus.imem_gnt, bus.dmem_rvalid}), 64'b11);
        @(negedge clk);
        check("cont_imem_rvalid", 64'(bus.imem_rvalid), 64'd1);
        wait_drain();

        // Starvation: dmem/imem held, imem wins every fifth cycle.
        for (int i = 0; i < 20; i++) begin
            agent_q[REQ_DMEM].push_back(mk(0, i, 0));
            agent_q[REQ_IMEM].push_back(mk(0, 100 + i, 0));
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("starve_pattern", 64'({bus.imem_gnt, bus.dmem_gnt}), (i % 5 == 4) ? 64'b10 : 64'b01);
        end
        wait_drain();

        // Halt: imem blocked and counter pinned at 0 while dbg reads proceed.
        @(posedge clk); #1 bus.halt_i = 1;
        agent_q[REQ_IMEM].push_back(mk(0, 3, 0));
        for (int i = 0; i <= 10; i++) agent_q[REQ_DBG].push_back(mk(0, i, 0));
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check("halt_no_imem", 64'({bus.imem_gnt, bus.starve_cnt}), 64'd0);
        end
        @(posedge clk); #1 bus.halt_i = 0;
        wait_drain();

        // Reset in the cycle after a dmem read grant.
        agent_q[REQ_DMEM].push_back(mk(0, 7, 0));
        @(negedge clk);
        check("rstmid_gnt", 64'(bus.dmem_gnt), 64'd1);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check("rstmid_rvalid", 64'({bus.dmem_rvalid, bus.mem_en, bus.rdata_o}), 64'd0);
        @(posedge clk); #1 rst = 0;
        wait_drain();

        // Back-to-back fetch: 11 grants, 11 contiguous returns.
        for (int i = 0; i <= 10; i++) agent_q[REQ_IMEM].push_back(mk(0, i, 0));
        first = -1; last = -1; cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_rvalid) begin
                if (first < 0) first = i;
                last = i; cnt++;
            end
        end
        check("b2b_count", 64'(cnt), 64'd11);
        check("b2b_span", 64'(last - first), 64'd10);
        wait_drain();

        // Random traffic with halt toggling.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (agent_q[REQ_DBG].size() < 2 && $urandom_range(0, 99) < 10)
                agent_q[REQ_DBG].push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom));
            if (agent_q[REQ_DMEM].size() < 2 && $urandom_range(0, 99) < 50)
                agent_q[REQ_DMEM].push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom));
            if (agent_q[REQ_IMEM].size() < 2 && $urandom_range(0, 99) < 60)
                agent_q[REQ_IMEM].push_back(mk(0, $urandom_range(0, 15), 0));
            if ($urandom_range(0, 99) < 5) bus.halt_i = ~bus.halt_i;
        end
        @(posedge clk); #1 bus.halt_i = 0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
